// File: rtl/pc_if.sv
// Program-counter bus: next-PC load request from the core's next-PC mux and
// the registered PC / PC+4 values returned to the fetch path.
// The misaligned flag exists only when PC_ALIGN_CHECK_EN is defined.
interface pc_if #(
  parameter int unsigned XLEN = 32
);
  logic            en;
  logic [XLEN-1:0] pc_in;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] pc_plus4;
`ifdef PC_ALIGN_CHECK_EN
  logic            misaligned;
`endif

`ifdef PC_ALIGN_CHECK_EN
  modport master (output en, output pc_in, input pc_out, input pc_plus4, input misaligned);
  modport slave  (input en, input pc_in, output pc_out, output pc_plus4, output misaligned);
`else
  modport master (output en, output pc_in, input pc_out, input pc_plus4);
  modport slave  (input en, input pc_in, output pc_out, output pc_plus4);
`endif
endinterface

// File: rtl/pc.sv
// Program-counter register for the single-cycle RISC-V core.
// Loads pc_in on each rising clk edge while en is high, holds otherwise.
// rst_n is an asynchronous ACTIVE-HIGH reset (the name is historical).
// Optional feature macro: PC_ALIGN_CHECK_EN -- forces loaded bits [1:0] to
// zero and adds a registered misaligned flag.
module pc #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input logic clk,
  input logic rst_n,
  pc_if.slave bus
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] load_val;

`ifdef PC_ALIGN_CHECK_EN
  logic mis_q;

  // Word-align the incoming next-PC value.
  always_comb begin
    load_val = {bus.pc_in[XLEN-1:2], 2'b00};
  end

  // Flag records whether the last accepted pc_in was misaligned.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)
      mis_q <= 1'b0;
    else if (bus.en)
      mis_q <= |bus.pc_in[1:0];
  end

  assign bus.misaligned = mis_q;
`else
  // Next-PC value loads unmodified.
  always_comb begin
    load_val = bus.pc_in;
  end
`endif

  // PC register: async reset to the reset vector, load when enabled.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)
      pc_q <= RESET_VECTOR;
    else if (bus.en)
      pc_q <= load_val;
  end

  assign bus.pc_out   = pc_q;
  assign bus.pc_plus4 = pc_q + XLEN'(4);

endmodule

// File: tb/tb_pc.sv
// Self-checking bench for pc: reset/load/stall/wrap vector table, directed
// async-reset and stall sequences, then randomized traffic against a model.
module tb_pc;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  pc_if #(.XLEN(32)) bus ();

  pc #(.XLEN(32), .RESET_VECTOR(RV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Value the register should hold after accepting v.
  function automatic logic [31:0] loaded(input logic [31:0] v);
`ifdef PC_ALIGN_CHECK_EN
    return v & ~32'h3;
`else
    return v;
`endif
  endfunction

  typedef struct {
    logic        rst;
    logic        en;
    logic [31:0] pc_in;
    logic [31:0] exp_pc;
    logic [31:0] exp_p4;
    logic        exp_mis;
  } vec_t;

  vec_t tbl[$];

  // Drive at the falling edge, let the rising edge act, sample 1 unit later.
  task automatic step(input logic r, input logic e, input logic [31:0] d);
    @(negedge clk);
    rst_n     = r;
    bus.en    = e;
    bus.pc_in = d;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] model_pc;
  logic        model_mis;
  logic        r;
  logic        e;
  logic [31:0] d;

  initial begin
    vectors     = 0;
    miscompares = 0;
    bus.en      = 1'b1;
    bus.pc_in   = '0;
    rst_n       = 1'b0;

    // Reset pulse of 10 time units with pc_in = 0, en = 1.
    #2;
    rst_n = 1'b1;
    #1;
    chk("reset_assert", bus.pc_out, RV);
`ifdef PC_ALIGN_CHECK_EN
    chk("reset_mis", 32'(bus.misaligned), 32'd0);
`endif
    #9;
    rst_n = 1'b0;
    #1;
    chk("reset_release", bus.pc_out, RV);

    // Table of single-edge vectors.
    tbl.push_back('{1'b0, 1'b1, 32'd4,  32'd4,  32'd8,  1'b0});
    tbl.push_back('{1'b0, 1'b1, 32'd8,  32'd8,  32'd12, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 32'd12, 32'd12, 32'd16, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 32'h100, 32'd12, 32'd16, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 1'b0});
`ifdef PC_ALIGN_CHECK_EN
    tbl.push_back('{1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 32'h0000_0006, 32'h0000_0004, 32'h8, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 32'h0000_0008, 32'h0000_0008, 32'hC, 1'b0});
`else
    tbl.push_back('{1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h3, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 32'h0000_0006, 32'h0000_0006, 32'hA, 1'b0});
`endif
    tbl.push_back('{1'b1, 1'b1, 32'h55, RV, RV + 32'd4, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 32'h77, RV, RV + 32'd4, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 32'h0,  32'h0, 32'h4, 1'b0});

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].pc_in);
      chk($sformatf("tbl%0d_pc", i), bus.pc_out, tbl[i].exp_pc);
      chk($sformatf("tbl%0d_p4", i), bus.pc_plus4, tbl[i].exp_p4);
`ifdef PC_ALIGN_CHECK_EN
      chk($sformatf("tbl%0d_mis", i), 32'(bus.misaligned), 32'(tbl[i].exp_mis));
`endif
    end

    // Stall: hold 8 for three edges while pc_in changes, then load.
    step(1'b0, 1'b1, 32'd8);
    chk("stall_pre", bus.pc_out, 32'd8);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'h100);
      chk("stall_hold", bus.pc_out, 32'd8);
    end
    step(1'b0, 1'b1, 32'h100);
    chk("stall_release", bus.pc_out, 32'h100);

    // Async reset between edges, held across edges, then released.
    step(1'b0, 1'b1, 32'h40);
    chk("mid_pre", bus.pc_out, 32'h40);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("mid_async", bus.pc_out, RV);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 32'h1234_5678);
      chk("mid_hold", bus.pc_out, RV);
    end
    step(1'b0, 1'b0, 32'h1234_5678);
    chk("mid_after_release", bus.pc_out, RV);
    step(1'b0, 1'b1, 32'h20);
    chk("mid_first_load", bus.pc_out, 32'h20);

    // Randomized traffic against a behavioural model.
    model_pc  = 32'h20;
    model_mis = 1'b0;
    for (int n = 0; n < 300; n++) begin
      r = ($urandom_range(0, 15) == 0);
      e = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       d = 32'hFFFF_FFFC;
        1:       d = $urandom & ~32'h3;
        default: d = $urandom;
      endcase
      step(r, e, d);
      if (r) begin
        model_pc  = RV;
        model_mis = 1'b0;
      end else if (e) begin
        model_pc  = loaded(d);
        model_mis = (d % 4) != 0;
      end
      chk("rand_pc", bus.pc_out, model_pc);
      chk("rand_p4", bus.pc_plus4, 32'((64'(model_pc) + 64'd4) % 64'h1_0000_0000));
`ifdef PC_ALIGN_CHECK_EN
      chk("rand_mis", 32'(bus.misaligned), 32'(model_mis));
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc.md
# pc

Program-counter register for the single-cycle RISC-V core. It holds the address of the instruction currently being fetched and loads the next-PC value selected by the core's next-PC mux on every rising clock edge. It sits at the head of the fetch path, and its output drives instruction-memory addressing and the PC+4/branch-target adders. A hold input supports stalls, and a combinational PC+4 output is provided for the sequential-path adder.

## Interface
Parameters:
- `XLEN`, default 32: address width in bits.
- `RESET_VECTOR`, default 32'h0000_0000: value loaded on reset; must be 4-byte aligned.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-high reset.
  - Asserted when 1, despite the `_n` suffix.
  - Clock and reset use the codebase port names; polarity and synchronicity are fixed.
- `en`  input  1  load enable: 1 = load `pc_in`, 0 = hold the current value (stall).
- `pc_in`  input  XLEN  next-PC value from the next-PC mux.
- `pc_out`  output  XLEN  current PC, registered.
- `pc_plus4`  output  XLEN  combinational `pc_out + 4`, modulo 2^XLEN.
- `misaligned`  output  1  registered flag: the last loaded `pc_in` had bits [1:0] ≠ 0. Present only under the macro below.

## Operation
- Single XLEN-bit register `pc_q`; `pc_out = pc_q`.
- Reset asserted (`rst_n = 1`):
  - `pc_q` is forced to RESET_VECTOR immediately, without waiting for a clock edge.
  - `misaligned` is forced to 0.
  - Reset dominates `en` and `pc_in`.
- Reset deasserted, on rising `clk`:
  - `en = 1`: `pc_q` ← `pc_in`.
  - `en = 0`: `pc_q` holds.
- `pc_plus4` is purely combinational from `pc_q`. Wrap-around: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no carry-out port.
- `pc_in` is accepted as-is; there is no range checking. Any value, including 0 and all-ones, loads unchanged unless alignment enforcement (Configuration) is compiled in.
- No internal state other than `pc_q` (plus the `misaligned` flop when configured).

## Timing
- Latency: `pc_in` sampled at rising edge N appears on `pc_out` immediately after edge N; one-cycle register delay.
- `pc_plus4` settles combinationally in the same cycle as `pc_out`.
- Reset assertion takes effect asynchronously, mid-cycle included. Any load in progress is discarded.
- Reset release:
  - Release must meet recovery/removal timing relative to `clk`.
  - The first load happens on the first rising edge after release with `en = 1`.
  - Until that edge, `pc_out` = RESET_VECTOR.
- Reset held across edges: `pc_out` stays at RESET_VECTOR regardless of `pc_in`/`en`.
- `en` toggling: it is sampled only at the rising edge; glitches between edges have no effect.

## Configuration
Macro: `PC_ALIGN_CHECK_EN`.
- Defined:
  - Bits [1:0] of the loaded value are forced to 2'b00 (word alignment).
  - The `misaligned` port exists. It is registered with the same enable/reset as `pc_q`, and is set to 1 when the loaded `pc_in[1:0]` ≠ 0, else 0.
- Undefined:
  - `pc_in` loads unmodified, all bits.
  - No `misaligned` port.

## Test plan
- Reset with `pc_in = 0`, `en = 1`: assert `rst_n = 1` for 10 time units, then release → `pc_out = 0` throughout and immediately after release.
- Sequential loads: after reset, drive `pc_in` = 4, 8, 12 on successive cycles with `en = 1` → `pc_out` reads 4, 8, 12, each one edge later; `pc_plus4` reads 8, 12, 16.
- Stall: with `pc_out = 8`, set `en = 0` and `pc_in = 32'h100` for 3 edges → `pc_out` stays 8. Set `en = 1` → next edge `pc_out = 32'h100`.
- Async reset mid-cycle: with `pc_out = 32'h40`, assert `rst_n` between clock edges → `pc_out = RESET_VECTOR` before the next edge, and it holds while asserted.
- Wrap: load 32'hFFFF_FFFC → `pc_plus4 = 0`. Load 32'hFFFF_FFFF with the macro undefined → `pc_out = 32'hFFFF_FFFF`.
- Macro defined: load 32'h0000_0006 → `pc_out = 32'h0000_0004` and `misaligned = 1`. Next load 32'h0000_0008 → `misaligned = 0`.
